cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Operand width WIDTH is split into GROUP_W-bit lookahead groups, one group per pipeline stage.
- Within a group, carries come from bit generate/propagate lookahead. Between groups, the carry is registered and passed to the next stage.
- valid/ready handshake on input and output, so it drops into the datapath between streaming blocks.
- Successor to the 4-bit single-cycle CLA. Adds width generality, subtract mode, overflow flag, pipelining and backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of GROUP_W and >= GROUP_W.
- GROUP_W, 4, bits per lookahead group (legal 2..8). NUM_GROUPS = WIDTH/GROUP_W = pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = A+B+cin, 1 = A-B-cin
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge): all stage valid bits 0, out_valid=0, s=0, cout=0, ovf=0. In-flight operations are discarded; no partial result ever appears.
- Operand conditioning at accept: b_eff = sub ? ~b : b; c_eff = cin ^ sub.
- Stage k (0..NUM_GROUPS-1):
  - computes bits [k*GROUP_W +: GROUP_W].
  - per bit: g = a&b_eff, p = a^b_eff.
  - carries inside the group: full lookahead (c[i+1] = g[i] | p[i]&c[i], expanded flat, no ripple).
  - sum bit = p ^ c.
  - group carry-out is registered for stage k+1.
  - upper, not-yet-summed operand bits travel with the token (skew registers); lower result bits are carried forward.
- Last stage:
  - cout = MSB group carry-out.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency: exactly NUM_GROUPS cycles from in_valid&in_ready to out_valid (4 at defaults). Throughput: one op/cycle when not stalled.
- Flow control: global pipeline enable adv = ~out_valid | out_ready.
  - in_ready = adv (combinational from out_valid/out_ready only, never from in_valid).
  - All stages shift when adv=1. Bubbles (in_valid=0) propagate as valid=0 stages. Nothing shifts when adv=0.
- Output hold: while out_valid=1 and out_ready=0, s/cout/ovf/out_valid are held stable.
- Ordering: results emerge in acceptance order; no loss, no duplication.
- Simultaneous events:
  - Accept and emit in the same cycle is legal.
  - Reset dominates every other input.
- Wrap-around: add/sub is modulo 2^WIDTH; cout/ovf report the wrap.
- Illegal parameters (WIDTH % GROUP_W != 0) abort elaboration via a generate-time error.

Optional Feature:
- CLA_PIPE_SAT_EN defined: signed saturation at the final stage.
  - If ovf=1: s = 0111..1 when the true result is positive (operand A MSB = 0), else 1000..0.
  - ovf still reports 1; cout is unchanged.
- Undefined: s is the raw modulo result; no saturation logic is instantiated.

Test Plan (defaults WIDTH=16, GROUP_W=4):
- Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, s=0, cout=0, ovf=0; no result for 4 cycles after release unless new ops are accepted.
- Add wrap: a=FFFF, b=0001, cin=0, sub=0 -> 4 cycles later s=0000, cout=1, ovf=0.
- Sub overflow: a=8000, b=0001, sub=1, cin=0 -> s=7FFF, cout=1, ovf=1. With CLA_PIPE_SAT_EN: s=8000, ovf=1.
- Add overflow with sat: a=7FFF, b=0001 -> s=8000, ovf=1 (raw); s=7FFF with CLA_PIPE_SAT_EN.
- Backpressure: stream 8 random ops back-to-back, out_ready low for cycles 5-9 -> in_ready low exactly while out_valid&~out_ready; all 8 results match the golden model in order, outputs stable while stalled.
- Reset mid-flight: accept 3 ops, assert rst_n=0 one cycle at cycle 2 -> out_valid stays 0; next accepted op returns correctly after 4 cycles.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// One GROUP_W-bit lookahead group is summed per stage; the group carry is registered between
// stages. Unsummed operand bits travel with each token, and finished low result bits are carried
// forward with it.
// Optional build macro CLA_PIPE_SAT_EN: saturate the result to the signed range on overflow.
module cla_pipe_adder #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned GROUP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NUM_GROUPS = WIDTH / GROUP_W;
   localparam int unsigned LAST       = (NUM_GROUPS > 0) ? NUM_GROUPS - 1 : 0;

   // Reject geometries that cannot be split into whole lookahead groups
   if (((WIDTH % GROUP_W) != 0) || (WIDTH < GROUP_W) || (GROUP_W < 2) || (GROUP_W > 8)) begin : g_param_check
      $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP_W, and GROUP_W must be 2..8");
   end

   logic             adv;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   // Whole pipeline advances together whenever the output slot is free or being drained
   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stg
      localparam int unsigned LO = k * GROUP_W;
      localparam int unsigned HI = LO + GROUP_W;

      logic              v_in;
      logic              c_in;
      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic [GROUP_W:0]  cy;
      logic [GROUP_W-1:0] grp_s;
      logic [HI-1:0]     sum_out;

      if (k == 0) begin : g_src
         // First stage conditions the operands: subtract is A + ~B + ~borrow
         assign v_in    = in_valid;
         assign c_in    = cin ^ sub;
         assign a_in    = a;
         assign b_in    = sub ? ~b : b;
         assign sum_out = grp_s;
      end else begin : g_src
         // Later stages take the token held by the previous stage
         assign v_in    = g_stg[k-1].g_reg.v_q;
         assign c_in    = g_stg[k-1].g_reg.c_q;
         assign a_in    = g_stg[k-1].g_reg.a_q;
         assign b_in    = g_stg[k-1].g_reg.b_q;
         assign sum_out = {grp_s, g_stg[k-1].g_reg.sum_q};
      end

      // Flat lookahead: every carry is a sum of generate/propagate products, no ripple chain
      always_comb begin
         logic [GROUP_W-1:0] g;
         logic [GROUP_W-1:0] p;
         logic               prod;
         logic               acc;
         g     = a_in[LO +: GROUP_W] & b_in[LO +: GROUP_W];
         p     = a_in[LO +: GROUP_W] ^ b_in[LO +: GROUP_W];
         prod  = 1'b0;
         acc   = 1'b0;
         cy    = '0;
         cy[0] = c_in;
         for (int i = 0; i < GROUP_W; i++) begin
            acc = c_in;
            for (int m = 0; m <= i; m++) begin
               acc = acc & p[m];
            end
            for (int j = 0; j <= i; j++) begin
               prod = g[j];
               for (int m = j + 1; m <= i; m++) begin
                  prod = prod & p[m];
               end
               acc = acc | prod;
            end
            cy[i+1] = acc;
         end
         grp_s = p ^ cy[GROUP_W-1:0];
      end

      if (k < LAST) begin : g_reg
         logic              v_q, v_d;
         logic              c_q, c_d;
         logic [WIDTH-1:HI] a_q, a_d;
         logic [WIDTH-1:HI] b_q, b_d;
         logic [HI-1:0]     sum_q, sum_d;

         // Next token: group carry, remaining operand bits, result bits finished so far
         always_comb begin
            v_d   = v_in;
            c_d   = cy[GROUP_W];
            a_d   = a_in[WIDTH-1:HI];
            b_d   = b_in[WIDTH-1:HI];
            sum_d = sum_out;
         end

         // Stage register; holds while the pipeline is stalled
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q   <= 1'b0;
               c_q   <= 1'b0;
               a_q   <= '0;
               b_q   <= '0;
               sum_q <= '0;
            end else if (adv) begin
               v_q   <= v_d;
               c_q   <= c_d;
               a_q   <= a_d;
               b_q   <= b_d;
               sum_q <= sum_d;
            end
         end
      end
   end

   // Final stage: MSB carries give cout and signed overflow; optional saturation
   always_comb begin
      out_valid_d = g_stg[LAST].v_in;
      s_d         = g_stg[LAST].sum_out;
      cout_d      = g_stg[LAST].cy[GROUP_W];
      ovf_d       = g_stg[LAST].cy[GROUP_W] ^ g_stg[LAST].cy[GROUP_W-1];
`ifdef CLA_PIPE_SAT_EN
      if (ovf_d) begin
         s_d = g_stg[LAST].a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Output register; held stable while downstream stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder at WIDTH=16, GROUP_W=4, against an integer reference model.
module tb_cla_pipe_adder;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned GROUP_W = 4;
   localparam int          LAT     = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(.WIDTH(WIDTH), .GROUP_W(GROUP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, then wrap; returns {ovf, cout, s}
   function automatic logic [17:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                         input logic fc, input logic fs);
      int          ua, ub, sa, sb, us, ss;
      logic [15:0] r;
      logic        co, ov;
      ua = int'(fa);
      ub = int'(fb);
      sa = int'($signed(fa));
      sb = int'($signed(fb));
      if (!fs) begin
         us = ua + ub + int'(fc);
         ss = sa + sb + int'(fc);
         co = (us > 65535);
      end else begin
         us = ua - ub - int'(fc);
         ss = sa - sb - int'(fc);
         co = (us >= 0);
      end
      r  = 16'(us);
      ov = (ss > 32767) || (ss < -32768);
`ifdef CLA_PIPE_SAT_EN
      if (ov) r = fa[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {ov, co, r};
   endfunction

   function automatic logic [15:0] pick_operand();
      logic [15:0] v;
      case ($urandom_range(0, 5))
         0: v = 16'h0000;
         1: v = 16'hFFFF;
         2: v = 16'h7FFF;
         3: v = 16'h8000;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one op into an idle pipeline and reports latency and the captured result
   task automatic issue_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                           input logic is, output int lat, output logic [17:0] got);
      out_ready = 1'b1;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      lat       = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
      got = {ovf, cout, s};
      tick();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'b1;
      sub       = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({out_valid, s, cout, ovf} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d got valid=%b s=%h cout=%b ovf=%b expected all zero",
                     i, out_valid, s, cout, ovf);
         end
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b expected 1", in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result cycle %0d got out_valid=%b expected 0", i, out_valid);
         end
      end
   endtask

   task automatic test_add_wrap();
      int          lat;
      logic [17:0] got;
      issue_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, got);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL add_wrap_latency got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (got !== {1'b0, 1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL add_wrap got %h expected %h", got, {1'b0, 1'b1, 16'h0000});
      end
      issue_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat, got);
      checks++;
      if (got !== {1'b0, 1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL add_wrap_cin got %h expected %h", got, {1'b0, 1'b1, 16'hFFFF});
      end
   endtask

   task automatic test_sub_ovf();
      int          lat;
      logic [17:0] got;
      logic [17:0] exp;
`ifdef CLA_PIPE_SAT_EN
      exp = {1'b1, 1'b1, 16'h8000};
`else
      exp = {1'b1, 1'b1, 16'h7FFF};
`endif
      issue_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, got);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL sub_ovf_latency got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL sub_ovf got %h expected %h", got, exp);
      end
      issue_op(16'h0000, 16'h0001, 1'b0, 1'b1, lat, got);
      checks++;
      if (got !== {1'b0, 1'b0, 16'hFFFF}) begin
         errors++;
         $display("FAIL sub_borrow got %h expected %h", got, {1'b0, 1'b0, 16'hFFFF});
      end
      issue_op(16'h0005, 16'h0003, 1'b1, 1'b1, lat, got);
      checks++;
      if (got !== {1'b0, 1'b1, 16'h0001}) begin
         errors++;
         $display("FAIL sub_borrow_in got %h expected %h", got, {1'b0, 1'b1, 16'h0001});
      end
   endtask

   task automatic test_add_ovf();
      int          lat;
      logic [17:0] got;
      logic [17:0] exp;
`ifdef CLA_PIPE_SAT_EN
      exp = {1'b1, 1'b0, 16'h7FFF};
`else
      exp = {1'b1, 1'b0, 16'h8000};
`endif
      issue_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL add_ovf got %h expected %h", got, exp);
      end
`ifdef CLA_PIPE_SAT_EN
      exp = {1'b1, 1'b1, 16'h8000};
`else
      exp = {1'b1, 1'b1, 16'h0000};
`endif
      issue_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, got);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL add_neg_ovf got %h expected %h", got, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] oa[8];
      logic [15:0] ob[8];
      logic        oc[8];
      logic        os[8];
      logic [17:0] expq[$];
      logic [17:0] e;
      logic [17:0] prev_out;
      logic        prev_stall;
      int          idx, got_n, stalls;
      for (int i = 0; i < 8; i++) begin
         oa[i] = pick_operand();
         ob[i] = pick_operand();
         oc[i] = 1'($urandom);
         os[i] = 1'($urandom);
      end
      idx        = 0;
      got_n      = 0;
      stalls     = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int cyc = 0; cyc < 60 && got_n < 8; cyc++) begin
         out_ready = !(cyc >= 5 && cyc <= 9);
         in_valid  = (idx < 8);
         if (idx < 8) begin
            a   = oa[idx];
            b   = ob[idx];
            cin = oc[idx];
            sub = os[idx];
         end
         @(negedge clk);
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready cycle %0d got %b expected %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (prev_stall) begin
            checks++;
            if ({out_valid, ovf, cout, s} !== {1'b1, prev_out}) begin
               errors++;
               $display("FAIL bp_hold cycle %0d got %h expected %h", cyc, {out_valid, ovf, cout, s}, {1'b1, prev_out});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {ovf, cout, s};
         if (prev_stall) stalls++;
         if (in_valid && in_ready) begin
            expq.push_back(model(a, b, cin, sub));
            idx++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL bp_spurious cycle %0d got result %h expected none", cyc, {ovf, cout, s});
            end else begin
               e = expq.pop_front();
               if ({ovf, cout, s} !== e) begin
                  errors++;
                  $display("FAIL bp_result %0d got %h expected %h", got_n, {ovf, cout, s}, e);
               end
            end
            got_n++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got_n != 8) begin
         errors++;
         $display("FAIL bp_count got %0d expected 8", got_n);
      end
      checks++;
      if (stalls != 5) begin
         errors++;
         $display("FAIL bp_stall_cycles got %0d expected 5", stalls);
      end
   endtask

   task automatic test_reset_midflight();
      int          lat;
      logic [17:0] got;
      logic [17:0] exp;
      logic [15:0] ra, rb;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a        = pick_operand();
         b        = pick_operand();
         cin      = 1'($urandom);
         sub      = 1'($urandom);
         in_valid = 1'b1;
         if (i == 2) rst_n = 1'b0;
         tick();
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_result cycle %0d got out_valid=%b expected 0", i, out_valid);
         end
         tick();
      end
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      exp = model(ra, rb, 1'b1, 1'b1);
      issue_op(ra, rb, 1'b1, 1'b1, lat, got);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL midreset_latency got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL midreset_result got %h expected %h", got, exp);
      end
   endtask

   task automatic test_random_stream();
      logic [17:0] expq[$];
      logic [17:0] e;
      logic [17:0] prev_out;
      logic        prev_stall;
      int          sent, got_n;
      sent       = 0;
      got_n      = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      in_valid   = 1'b0;
      for (int cyc = 0; cyc < 2000 && got_n < 120; cyc++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid && sent < 120 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            a        = pick_operand();
            b        = pick_operand();
            cin      = 1'($urandom);
            sub      = 1'($urandom);
         end
         @(negedge clk);
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL rnd_in_ready cycle %0d got %b expected %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (prev_stall) begin
            checks++;
            if ({out_valid, ovf, cout, s} !== {1'b1, prev_out}) begin
               errors++;
               $display("FAIL rnd_hold cycle %0d got %h expected %h", cyc, {out_valid, ovf, cout, s}, {1'b1, prev_out});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {ovf, cout, s};
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious cycle %0d got result %h expected none", cyc, {ovf, cout, s});
            end else begin
               e = expq.pop_front();
               if ({ovf, cout, s} !== e) begin
                  errors++;
                  $display("FAIL rnd_result %0d got %h expected %h", got_n, {ovf, cout, s}, e);
               end
            end
            got_n++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(a, b, cin, sub));
            sent++;
            tick();
            in_valid = 1'b0;
         end else begin
            tick();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got_n != 120) begin
         errors++;
         $display("FAIL rnd_count got %0d expected 120", got_n);
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_add_wrap();
      test_sub_ovf();
      test_add_ovf();
      test_backpressure();
      test_reset_midflight();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog timeout reached expected completion");
      $fatal(1, "timeout");
   end

endmodule
